mdu: RTL and testbench
======================

# mdu

Execute-stage multiply/divide unit with HI/LO registers. It sits beside the ALU and takes the same forwarded SrcA/SrcB operands. It runs multi-cycle MIPS mult/multu/div/divu, services mthi/mtlo writes, and exposes HI/LO for mfhi/mflo. Issue logic in D uses busy to stall any MDU instruction while an operation is running.

## Interface
- MUL_CYCLES, 5: cycles busy stays high for mult/multu (and madd family); must be ≥1.
- DIV_CYCLES, 10: cycles busy stays high for div/divu; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  MDU instruction present in E this cycle.
- MDU_CTR  in  4  op code, sampled when req=1.
- SrcA  in  32  rs operand (forwarded).
- SrcB  in  32  rt operand (forwarded).
- flush  in  1  cancels a running operation (exception/interrupt in M).
- busy  out  1  operation in flight.
- HI_E  out  32  current HI register.
- LO_E  out  32  current LO register.

## Operation
- MDU_CTR codes:
  - 0000 none.
  - 0001 mult, 0010 multu, 0011 div, 0100 divu.
  - 0101 mthi, 0110 mtlo.
  - 0111 madd, 1000 maddu, 1001 msub, 1010 msubu (macro only).
  - All other codes: no-op.
- States: IDLE (busy=0) and RUN (busy=1). A down-counter `cnt` holds the remaining cycles; busy = (cnt != 0).
- IDLE, req with mult/multu: operands are captured, the 64-bit product {hi,lo} is computed into pending registers, cnt ← MUL_CYCLES, go to RUN.
- IDLE, req with div/divu: pending lo ← quotient, hi ← remainder, cnt ← DIV_CYCLES, go to RUN.
- Arithmetic rules:
  - Signed ops truncate toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divide by zero still takes DIV_CYCLES; HI/LO stay unchanged on commit.
- RUN: cnt decrements every cycle. On the edge where cnt goes 1→0, {HI,LO} ← pending (commit) and the state returns to IDLE.
- mthi/mtlo with req in IDLE: HI or LO ← SrcA at the next edge. busy is not asserted.
- Any req while busy=1 is ignored (protocol violation; D-stage stall prevents it). The bench flags it with an assertion.
- flush=1: cnt ← 0 and pending is discarded, so HI/LO keep their pre-op values. A req in the same cycle is also dropped. flush has priority over commit.
- Reset: HI_E=0, LO_E=0, busy=0, cnt=0, pending=0.

## Timing
- req sampled at edge t0. busy is high from after t0 until the commit edge t0+N (N = MUL_CYCLES or DIV_CYCLES). HI_E/LO_E show the new value and busy=0 in the same cycle after t0+N.
- mthi/mtlo: new value is visible one cycle after the req edge.
- HI_E/LO_E are registered outputs with no combinational path from SrcA/SrcB. mfhi in the first cycle after commit reads the new value.
- A req for a new op in the first cycle with busy=0 is accepted, so back-to-back ops are spaced exactly N+1 cycles.
- flush while busy: busy=0 from the next cycle.
- Reset asserted mid-operation: all state clears immediately, with no commit.

## Configuration
- MDU_MADD_EN defined: codes 0111–1010 are decoded.
  - madd/maddu: pending ← {HI,LO} + product (signed or unsigned).
  - msub/msubu: pending ← {HI,LO} − product.
  - {HI,LO} is sampled at the req edge. Latency is MUL_CYCLES.
- MDU_MADD_EN undefined: codes 0111–1010 are no-ops, busy stays 0, and no accumulate adder is synthesised.

## Structure
- Shared package mdu_pkg holds:
  - MDU_CTR localparams (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD…).
  - Default latency constants.
- The D-stage stall unit imports the same codes.
- One sub-module: mdu_calc, combinational. It takes op, SrcA, SrcB, HI, LO and returns the 64-bit pending result and a div-by-zero flag. mdu holds only the counter, pending registers and HI/LO.

## Test plan
- mult 0xFFFFFFFF × 0x00000002 (signed) → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu of the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD after 10 cycles. divu 7/0 → HI/LO unchanged, busy still 10 cycles.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → both registers updated, busy never asserted.
- Start mult, assert flush on cycle 3 → busy drops the next cycle, HI/LO keep their old values. Issue a new mult the next cycle and it is accepted.
- Assert reset mid-divide → HI=LO=0 and busy=0 immediately, with no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1×1 → HI=1, LO=0. Without the macro, the same code leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : MDU op codes, state encoding and default latencies (MDU_MADD_EN)
// Revision: 1.0
// ============================================================================
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;
  localparam logic [3:0] MDU_MADD  = 4'b0111;
  localparam logic [3:0] MDU_MADDU = 4'b1000;
  localparam logic [3:0] MDU_MSUB  = 4'b1001;
  localparam logic [3:0] MDU_MSUBU = 4'b1010;

  localparam int MDU_MUL_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Accumulate codes only count as multiplies when the accumulate option is built.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
           (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// mdu_calc : combinational multiply/divide/accumulate datapath (MDU_MADD_EN)
// Revision: 1.0
// ============================================================================
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        signed_op;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV) ||
                (op == MDU_MADD) || (op == MDU_MSUB);
    ext_a = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ext_a * ext_b;

    // Divide on magnitudes, then fix signs: truncation toward zero, remainder
    // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    mag_a    = (signed_op && a[31]) ? (32'd0 - a) : a;
    mag_b    = (signed_op && b[31]) ? (32'd0 - b) : b;
    div_zero = is_div_op(op) && (b == 32'd0);
    divisor  = (b == 32'd0) ? 32'd1 : mag_b;
    quo      = mag_a / divisor;
    rem      = mag_a % divisor;
    if (signed_op && (a[31] ^ b[31])) quo = 32'd0 - quo;
    if (signed_op && a[31])           rem = 32'd0 - rem;

    result = {hi, lo};
    case (op)
      MDU_MULT, MDU_MULTU: result = prod;
      MDU_DIV, MDU_DIVU:   result = (b == 32'd0) ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: result = {hi, lo} + prod;
      MDU_MSUB, MDU_MSUBU: result = {hi, lo} - prod;
`endif
      default:             result = {hi, lo};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// mdu : multi-cycle MIPS multiply/divide unit with HI/LO (MDU_MADD_EN option)
// Revision: 1.0
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  MDU_CTR,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI_E,
  output logic [31:0] LO_E
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_t  state;
  logic [CW-1:0] cnt;
  logic [63:0] pend;
  logic        pend_dz;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .op       (MDU_CTR),
    .a        (SrcA),
    .b        (SrcB),
    .hi       (hi),
    .lo       (lo),
    .result   (calc_res),
    .div_zero (calc_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // flush cancels any request presented in the same cycle
          if (req && !flush) begin
            if (is_mul_op(MDU_CTR)) begin
              pend    <= calc_res;
              pend_dz <= 1'b0;
              cnt     <= CW'(MUL_CYCLES);
              state   <= ST_RUN;
            end else if (is_div_op(MDU_CTR)) begin
              pend    <= calc_res;
              pend_dz <= calc_dz;
              cnt     <= CW'(DIV_CYCLES);
              state   <= ST_RUN;
            end else if (MDU_CTR == MDU_MTHI) begin
              hi <= SrcA;
            end else if (MDU_CTR == MDU_MTLO) begin
              lo <= SrcA;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            cnt     <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (!pend_dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (cnt != '0);
  assign HI_E = hi;
  assign LO_E = lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// tb_mdu : self-checking bench for mdu (vector table, corner sequences, random)
// Revision: 1.0
// ============================================================================
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  MDU_CTR;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        busy;
  logic [31:0] HI_E;
  logic [31:0] LO_E;

  int passed = 0;
  int total  = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .MDU_CTR (MDU_CTR),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .flush   (flush),
    .busy    (busy),
    .HI_E    (HI_E),
    .LO_E    (LO_E)
  );

  always #5 clk = ~clk;

  // Issue logic must never present an MDU op while one is running.
  always @(posedge clk) begin
    if (!reset) assert (!(req && busy && MDU_CTR != 4'd0))
      else $error("protocol violation: req while busy");
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int model_lat(input logic [3:0] op);
    if (op inside {4'd1, 4'd2}) return 5;
    if (op inside {4'd3, 4'd4}) return 10;
`ifdef MDU_MADD_EN
    if (op inside {4'd7, 4'd8, 4'd9, 4'd10}) return 5;
`endif
    return 0;
  endfunction

  // Reference behaviour from the architectural definition of each op.
  function automatic void model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    longint unsigned acc;
    int              sa, sb;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = longint'({32'd0, a}) * longint'({32'd0, b});
    acc = {hi_m, lo_m};
    sa  = a;
    sb  = b;
    case (op)
      4'd1: {hi_m, lo_m} = sp;
      4'd2: {hi_m, lo_m} = up;
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 32'h0;
        end else begin
          lo_m = sa / sb; hi_m = sa % sb;
        end
      end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
`ifdef MDU_MADD_EN
      4'd7:  {hi_m, lo_m} = acc + sp;
      4'd8:  {hi_m, lo_m} = acc + up;
      4'd9:  {hi_m, lo_m} = acc - sp;
      4'd10: {hi_m, lo_m} = acc - up;
`endif
      default: ;
    endcase
  endfunction

  // Called at a negedge; presents one req, measures busy width, checks HI/LO.
  task automatic issue_check(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int exp_lat);
    int n;
    MDU_CTR = op; SrcA = a; SrcB = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0; MDU_CTR = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 64'(n), 64'(exp_lat));
    check({name, " hi/lo"}, {HI_E, LO_E}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{"mult -1x2",     4'd1, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{"multu",         4'd2, 32'hFFFF_FFFF, 32'h2,          32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div -7/2",      4'd3, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu 7/0",      4'd4, 32'h7,         32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{"div ovf",       4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000, 10};
    vecs[5] = '{"divu 100/7",    4'd4, 32'd100,       32'd7,          32'd2,         32'd14,        10};
    vecs[6] = '{"div 7/-2",      4'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10};
    vecs[7] = '{"mult 2^16sq",   4'd1, 32'h0001_0000, 32'h0001_0000,  32'd1,         32'd0,         5};
    vecs[8] = '{"nop code 15",   4'd15, 32'h1234,     32'h5678,       32'd1,         32'd0,         0};

    reset = 1'b1; req = 1'b0; MDU_CTR = 4'd0; SrcA = '0; SrcB = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi/lo", {HI_E, LO_E}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      issue_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);
    hi_m = 32'd1; lo_m = 32'd0;

    // mthi/mtlo on consecutive cycles never raise busy
    MDU_CTR = 4'd5; SrcA = 32'h1234_5678; req = 1'b1;
    @(negedge clk);
    check("mthi hi", {32'd0, HI_E}, {32'd0, 32'h1234_5678});
    check("mthi busy", {63'd0, busy}, 64'd0);
    MDU_CTR = 4'd6; SrcA = 32'h9ABC_DEF0;
    @(negedge clk);
    req = 1'b0; MDU_CTR = 4'd0;
    check("mtlo hi/lo", {HI_E, LO_E}, {32'h1234_5678, 32'h9ABC_DEF0});
    check("mtlo busy", {63'd0, busy}, 64'd0);
    hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;

    // flush on the third busy cycle discards the pending product
    MDU_CTR = 4'd1; SrcA = 32'd3; SrcB = 32'd4; req = 1'b1;
    @(negedge clk);
    req = 1'b0; MDU_CTR = 4'd0;
    check("flush pre busy", {63'd0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy drop", {63'd0, busy}, 64'd0);
    check("flush hi/lo kept", {HI_E, LO_E}, {hi_m, lo_m});
    issue_check("mult after flush", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    hi_m = 32'd0; lo_m = 32'd12;

    // asynchronous reset mid-divide clears everything with no late commit
    issue_check("mthi pre-reset", 4'd5, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'd12, 0);
    MDU_CTR = 4'd4; SrcA = 32'd100; SrcB = 32'd7; req = 1'b1;
    @(negedge clk);
    req = 1'b0; MDU_CTR = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset mid busy", {63'd0, busy}, 64'd0);
    check("reset mid hi/lo", {HI_E, LO_E}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("no commit after reset", {HI_E, LO_E}, 64'd0);
    check("idle after reset", {63'd0, busy}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;

    // maddu 1x1 onto {0, 0xFFFFFFFF}
    issue_check("mthi 0", 4'd5, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    issue_check("mtlo ff", 4'd6, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
`ifdef MDU_MADD_EN
    issue_check("maddu 1x1", 4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    hi_m = 32'd1; lo_m = 32'd0;
`else
    issue_check("maddu disabled", 4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    hi_m = 32'd0; lo_m = 32'hFFFF_FFFF;
`endif

    // randomized ops against the reference model, issued back-to-back
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model_step(op, a, b);
      issue_check($sformatf("rand%0d op%0d", k, op), op, a, b, hi_m, lo_m, model_lat(op));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
